// File: rtl/accel_ctrl_master.sv
`default_nettype none
// ============================================================================
// Module      : accel_ctrl_master
// Description : AXI4-Lite initiator for the accelerator control bus. Each
//               host command becomes one AXI4-Lite register read or write,
//               and only one transaction is in flight at a time. The module
//               returns the slave's data and response code, and it raises
//               timeout when a transaction has stalled too long.
// Ports       : aclk/areset      - clock, asynchronous active-high reset
//               cmd_*            - host command (valid/ready, write, addr, wdata)
//               rsp_*            - response to host (valid/ready, rdata, resp)
//               timeout          - current transaction hit TIMEOUT_CYCLES
//               aw*/w*/b*        - AXI4-Lite write address/data/response
//               ar*/r*           - AXI4-Lite read address/data
// Revision    : 1.0 - initial release
// ============================================================================
module accel_ctrl_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  aclk,
    input  logic                  areset,
    // host command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // host response
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  timeout,
    // AXI4-Lite write address
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    // AXI4-Lite write data
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    // AXI4-Lite write response
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    // AXI4-Lite read address
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    // AXI4-Lite read data
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    // The counter must be able to hold TIMEOUT_CYCLES itself, because it
    // saturates there.
    localparam int                C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_TMO  = C_CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WRESP   = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t             r_state;
    logic [C_CNT_W-1:0] r_count;

    // A write channel counts as done once its valid has already dropped, or
    // when its handshake completes on this edge.
    logic w_aw_done;
    logic w_w_done;
    logic w_busy;

    assign w_aw_done = !awvalid || awready;
    assign w_w_done  = !wvalid  || wready;
    assign w_busy    = (r_state == S_WR)      || (r_state == S_WRESP) ||
                       (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);
    assign timeout   = (r_count == C_TMO);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            // The counter increments while any bus phase is waiting. It
            // saturates at the limit, and it holds through RSP and IDLE
            // until the next accept clears it.
            if (w_busy && (r_count != C_TMO)) begin
                r_count <= r_count + C_CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        r_count   <= '0;
                        if (cmd_write) begin
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            r_state <= S_WR;
                        end else begin
                            araddr  <= cmd_addr;
                            arvalid <= 1'b1;
                            r_state <= S_RD_ADDR;
                        end
                    end
                end

                S_WR: begin
                    // Address and data handshakes are independent. Each
                    // valid drops after its own handshake completes.
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        bready  <= 1'b1;
                        r_state <= S_WRESP;
                    end
                end

                S_WRESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_resp  <= bresp;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        r_state   <= S_RSP;
                    end
                end

                S_RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= S_RD_DATA;
                    end
                end

                S_RD_DATA: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_rdata <= rdata;
                        rsp_resp  <= rresp;
                        rsp_valid <= 1'b1;
                        r_state   <= S_RSP;
                    end
                end

                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
